// File: rtl/accum_pkg.sv
// Shared constants for the accum_stream block.
// State encodings and default operand/counter widths.
package accum_pkg;

    localparam int WIDTH_DEF = 4;
    localparam int CNT_W_DEF = 4;

    localparam logic [0:0] ST_ACCUM = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;

endpackage

// File: rtl/accum_stream_if.sv
// Operand-in / result-out handshake bundle for accum_stream.
// slave = the accumulator, master = the surrounding logic.
interface accum_stream_if
    import accum_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic [CNT_W-1:0] out_carries;

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_sum,
        output out_carries
    );

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_sum,
        input  out_carries
    );

endinterface

// File: rtl/accum_stream_add_ripple.sv
// Ripple-carry adder built from a chain of add1 full-adder cells.
// Purely combinational.
module add1 (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

module add_ripple #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic [WIDTH-1:0] s,
    output logic             co
);

    logic [WIDTH:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        add1 u_add1 (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c[i]),
            .s  (s[i]),
            .co (c[i+1])
        );
    end

    assign co = c[WIDTH];

endmodule

// File: rtl/accum_stream.sv
// Packet accumulator: sums beats, reports sum and carry count per packet.
// Define ACCUM_SAT_EN to clamp the sum to all-ones after the first carry.
module accum_stream
    import accum_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    accum_stream_if.slave bus
);

    logic [0:0]       state_q;
    logic [0:0]       state_d;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [WIDTH-1:0] sum_q;
    logic [CNT_W-1:0] car_q;
    logic             rdy_q;
    logic             vld_q;
    logic [WIDTH-1:0] s;
    logic             co;
    logic             in_fire;
    logic             out_fire;

    add_ripple #(.WIDTH(WIDTH)) u_add (
        .a  (acc_q),
        .b  (bus.in_data),
        .ci (1'b0),
        .s  (s),
        .co (co)
    );

    assign in_fire  = bus.in_valid & rdy_q;
    assign out_fire = vld_q & bus.out_ready;

    always_comb begin
        cnt_d = cnt_q;
        if (co && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

`ifdef ACCUM_SAT_EN
    logic ov_q;
    logic ov_d;

    // once overflowed, the sum is pinned at all-ones
    always_comb begin
        ov_d  = ov_q | co;
        acc_d = ov_d ? '1 : s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ov_q <= 1'b0;
        end else if (in_fire) begin
            ov_q <= bus.in_last ? 1'b0 : ov_d;
        end
    end
`else
    always_comb begin
        acc_d = s;
    end
`endif

    always_comb begin
        state_d = state_q;
        unique case (1'b1)
            in_fire && bus.in_last: state_d = ST_HOLD;
            out_fire:               state_d = ST_ACCUM;
            default:                state_d = state_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            car_q   <= '0;
            rdy_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= (state_d == ST_ACCUM);
            vld_q   <= (state_d == ST_HOLD);
            if (in_fire) begin
                if (bus.in_last) begin
                    sum_q <= acc_d;
                    car_q <= cnt_d;
                    acc_q <= '0;
                    cnt_q <= '0;
                end else begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_d;
                end
            end
        end
    end

    assign bus.in_ready    = rdy_q;
    assign bus.out_valid   = vld_q;
    assign bus.out_sum     = sum_q;
    assign bus.out_carries = car_q;

endmodule
